// File: rtl/pre_pkg.sv
// Shared definitions for the symmetry-fold preprocessor: fold mode encodings and
// small width/lane-indexing helpers used by pre_fold_pipe and pre_fold_lane.
package pre_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ODD  = 2'b01;
    localparam logic [1:0] MODE_EVEN = 2'b10;

    function automatic int fold_width(input int m, input int n);
        return m + n;
    endfunction

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int lane_base(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/pre_fold_lane.sv
// Combinational fold of one signed lane: abs for ODD/EVEN with saturation of the
// most-negative code, then clamp of the magnitude to XMAX; PASS leaves the lane untouched.
module pre_fold_lane
    import pre_pkg::*;
#(
    parameter int W    = 12,
    parameter int XMAX = (1 << (W - 1)) - 1
) (
    input  logic [W-1:0] x,
    input  logic [1:0]   mode,
    output logic [W-1:0] y,
    output logic         neg,
    output logic         flag
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-2:0] LIMIT    = XMAX[W-2:0];

    logic         fold;
    logic         sat;
    logic [W-1:0] mag;

    // Mode 11 falls through to PASS because fold only recognises ODD and EVEN.
    always_comb begin
        fold = (mode == MODE_ODD) || (mode == MODE_EVEN);
        sat  = (x == MOST_NEG);
        mag  = sat ? MOST_POS : (x[W-1] ? -x : x);
        y    = x;
        neg  = 1'b0;
        flag = 1'b0;
        if (fold) begin
            neg  = (mode == MODE_ODD) && x[W-1];
            flag = sat;
            y    = mag;
            if (mag[W-2:0] > LIMIT) begin
                y    = {1'b0, LIMIT};
                flag = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pre_fold_pipe.sv
// Multi-lane sign/abs fold preprocessor with a 2-stage valid/ready pipe and sideband.
// Optional flagged-lane statistics counter enabled by defining PRE_FOLD_STATS_EN.
module pre_fold_pipe
    import pre_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 8,
    parameter int LANES = 4,
    parameter int XMAX  = (1 << (M + N - 1)) - 1,
    parameter int CNT_W = 16,
    localparam int W    = fold_width(M, N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [LANES*W-1:0] x_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] x_out,
    output logic [LANES-1:0]   sign_out,
    output logic [LANES-1:0]   neg_out,
`ifdef PRE_FOLD_STATS_EN
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   flag_cnt,
`endif
    output logic [LANES-1:0]   flag_out
);

    logic               s1_v;
    logic [LANES*W-1:0] s1_x;
    logic [1:0]         s1_mode;
    logic [LANES-1:0]   s1_sign;
    logic               s2_v;

    logic               s1_load;
    logic               s2_load;
    logic [LANES-1:0]   in_sign;
    logic [LANES*W-1:0] fold_x;
    logic [LANES-1:0]   fold_neg;
    logic [LANES-1:0]   fold_flag;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_sign[i] = x_in[lane_base(i, W) + W - 1];

        pre_fold_lane #(
            .W    (W),
            .XMAX (XMAX)
        ) u_lane (
            .x    (s1_x[lane_base(i, W) +: W]),
            .mode (s1_mode),
            .y    (fold_x[lane_base(i, W) +: W]),
            .neg  (fold_neg[i]),
            .flag (fold_flag[i])
        );
    end

    // Stage 2 frees up whenever the consumer takes it, so a full pipe still accepts under flow.
    always_comb begin
        s2_load  = !s2_v || out_ready;
        s1_load  = !s1_v || s2_load;
        in_ready = !rst && s1_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_x      <= '0;
            s1_mode   <= MODE_PASS;
            s1_sign   <= '0;
            s2_v      <= 1'b0;
            x_out     <= '0;
            sign_out  <= '0;
            neg_out   <= '0;
            flag_out  <= '0;
        end else begin
            if (s1_load) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_x    <= x_in;
                    s1_mode <= in_mode;
                    s1_sign <= in_sign;
                end
            end
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    x_out    <= fold_x;
                    sign_out <= s1_sign;
                    neg_out  <= fold_neg;
                    flag_out <= fold_flag;
                end
            end
        end
    end

    assign out_valid = s2_v;

`ifdef PRE_FOLD_STATS_EN
    logic [CNT_W-1:0] pop;
    logic [CNT_W:0]   sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + CNT_W'(flag_out[i]);
        end
        sum = {1'b0, flag_cnt} + {1'b0, pop};
    end

    // Clear takes priority over a beat leaving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            flag_cnt <= '0;
        end else if (out_valid && out_ready) begin
            flag_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_pre_fold_pipe.sv
// Directed bench for pre_fold_pipe: one default-range DUT and one with XMAX=0x400,
// sharing stimulus; covers fold modes, saturation, clamp, stall flow, reset flush and stats.
module tb_pre_fold_pipe;
    import pre_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_c;
    logic [1:0]  in_mode;
    logic [47:0] x_in;
    logic        out_valid, out_valid_c;
    logic        out_ready;
    logic [47:0] x_out, x_out_c;
    logic [3:0]  sign_out, sign_out_c;
    logic [3:0]  neg_out, neg_out_c;
    logic [3:0]  flag_out, flag_out_c;
`ifdef PRE_FOLD_STATS_EN
    logic        cnt_clr;
    logic [15:0] flag_cnt, flag_cnt_c;
`endif

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    pre_fold_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .sign_out  (sign_out),
        .neg_out   (neg_out),
`ifdef PRE_FOLD_STATS_EN
        .cnt_clr   (cnt_clr),
        .flag_cnt  (flag_cnt),
`endif
        .flag_out  (flag_out)
    );

    pre_fold_pipe #(.XMAX('h400)) dutc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_c),
        .in_mode   (in_mode),
        .x_in      (x_in),
        .out_valid (out_valid_c),
        .out_ready (out_ready),
        .x_out     (x_out_c),
        .sign_out  (sign_out_c),
        .neg_out   (neg_out_c),
`ifdef PRE_FOLD_STATS_EN
        .cnt_clr   (cnt_clr),
        .flag_cnt  (flag_cnt_c),
`endif
        .flag_out  (flag_out_c)
    );

    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [47:0] x,
                                 input logic r);
        in_valid  = v;
        in_mode   = m;
        x_in      = x;
        out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s check did not match", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [47:0] expq [8];
        int sent;
        int recv;
        int occ;
        logic fireIn;
        logic fireOut;

        rst = 1'b1;
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
`ifdef PRE_FOLD_STATS_EN
        cnt_clr = 1'b0;
`endif
        step();
        step();
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_x_out", 64'(x_out), 64'(0));
        checkOutput("rst_sign", 64'(sign_out), 64'(0));
        checkOutput("rst_neg", 64'(neg_out), 64'(0));
        checkOutput("rst_flag", 64'(flag_out), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Single ODD beat: latency and values on both DUTs.
        applyStimulus(1'b1, MODE_ODD, 48'h000_3FF_B00_E80, 1'b1);
        step();
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
        checkOutput("odd_lat1_valid", 64'(out_valid), 64'(0));
        step();
        checkOutput("odd_valid", 64'(out_valid), 64'(1));
        checkOutput("odd_x", 64'(x_out), 64'(48'h000_3FF_500_180));
        checkOutput("odd_sign", 64'(sign_out), 64'(4'b0011));
        checkOutput("odd_neg", 64'(neg_out), 64'(4'b0011));
        checkOutput("odd_flag", 64'(flag_out), 64'(4'b0000));
        checkOutput("odd_clamp_x", 64'(x_out_c), 64'(48'h000_3FF_400_180));
        checkOutput("odd_clamp_neg", 64'(neg_out_c), 64'(4'b0011));
        checkOutput("odd_clamp_flag", 64'(flag_out_c), 64'(4'b0010));
        step();
        checkOutput("odd_drain_valid", 64'(out_valid), 64'(0));

        // Back-to-back EVEN, PASS and mode-11 beats.
        applyStimulus(1'b1, MODE_EVEN, 48'h801_7FF_FFF_800, 1'b1);
        step();
        applyStimulus(1'b1, MODE_PASS, 48'h801_7FF_FFF_800, 1'b1);
        step();
        checkOutput("even_valid", 64'(out_valid), 64'(1));
        checkOutput("even_x", 64'(x_out), 64'(48'h7FF_7FF_001_7FF));
        checkOutput("even_sign", 64'(sign_out), 64'(4'b1011));
        checkOutput("even_neg", 64'(neg_out), 64'(4'b0000));
        checkOutput("even_flag", 64'(flag_out), 64'(4'b0001));
        checkOutput("even_clamp_x", 64'(x_out_c), 64'(48'h400_400_001_400));
        checkOutput("even_clamp_flag", 64'(flag_out_c), 64'(4'b1101));
        applyStimulus(1'b1, 2'b11, 48'h000_3FF_B00_E80, 1'b1);
        step();
        checkOutput("pass_valid", 64'(out_valid), 64'(1));
        checkOutput("pass_x", 64'(x_out), 64'(48'h801_7FF_FFF_800));
        checkOutput("pass_sign", 64'(sign_out), 64'(4'b1011));
        checkOutput("pass_flag", 64'(flag_out), 64'(4'b0000));
        checkOutput("pass_clamp_x", 64'(x_out_c), 64'(48'h801_7FF_FFF_800));
        checkOutput("pass_clamp_flag", 64'(flag_out_c), 64'(4'b0000));
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
        step();
        checkOutput("mode3_x", 64'(x_out), 64'(48'h000_3FF_B00_E80));
        checkOutput("mode3_neg", 64'(neg_out), 64'(4'b0000));
        checkOutput("mode3_flag", 64'(flag_out), 64'(4'b0000));
        checkOutput("mode3_sign", 64'(sign_out), 64'(4'b0011));
        step();
        checkOutput("mode3_drain_valid", 64'(out_valid), 64'(0));

        // 8-beat stream with out_ready low on cycles 3..5.
        for (int i = 0; i < 8; i++) begin
            expq[i] = {4{12'(16 * i + 1)}} ^ 48'h300_200_100_000;
        end
        sent = 0;
        recv = 0;
        occ  = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            applyStimulus(sent < 8, MODE_PASS, (sent < 8) ? expq[sent] : 48'h0,
                          !(cyc >= 3 && cyc <= 5));
            #1;
            checkOutput("stream_in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
            fireIn  = in_valid && in_ready;
            fireOut = out_valid && out_ready;
            if (fireOut) begin
                checkOutput("stream_data", 64'(x_out), 64'(expq[recv]));
                recv++;
            end
            if (fireIn) sent++;
            occ = occ + int'(fireIn) - int'(fireOut);
            step();
        end
        checkOutput("stream_count", 64'(recv), 64'(8));
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
        step();
        checkOutput("stream_drain_valid", 64'(out_valid), 64'(0));

        // Reset with two beats held in the pipe.
        applyStimulus(1'b1, MODE_ODD, 48'h111_222_333_444, 1'b0);
        step();
        applyStimulus(1'b1, MODE_ODD, 48'h555_666_777_888, 1'b0);
        step();
        checkOutput("full_in_ready", 64'(in_ready), 64'(0));
        checkOutput("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
        #1;
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(0));
        step();
        checkOutput("mid_rst_valid", 64'(out_valid), 64'(0));
        checkOutput("mid_rst_x", 64'(x_out), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_rst_no_stale", 64'(out_valid), 64'(0));
        end

`ifdef PRE_FOLD_STATS_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checkOutput("cnt_cleared", 64'(flag_cnt), 64'(0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, MODE_EVEN, 48'h000_000_800_800, 1'b1);
            step();
        end
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
        step();
        step();
        checkOutput("cnt_six", 64'(flag_cnt), 64'(6));
        checkOutput("cnt_six_clamp", 64'(flag_cnt_c), 64'(6));
        applyStimulus(1'b1, MODE_EVEN, 48'h000_000_800_800, 1'b1);
        step();
        applyStimulus(1'b0, MODE_PASS, 48'h0, 1'b1);
        step();
        checkOutput("cnt_clr_beat_valid", 64'(out_valid), 64'(1));
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checkOutput("cnt_clr_wins", 64'(flag_cnt), 64'(0));
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
